// File: rtl/multi_cycle_controller_pkg.sv
// ============================================================================
// multi_cycle_controller_pkg : encodings and per-state control decode
// Rev 1.0
// ============================================================================
`default_nettype none

package multi_cycle_controller_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_INIT, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
    S_R_EXEC, S_R_WB, S_BRANCH, S_I_EXEC, S_I_WB, S_JUMP, S_JAL, S_JR
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       jal_reg;
    logic       mem_to_reg;
    logic       pc_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_cntrl;
    logic [1:0] pc_src;
  } ctrl_t;

  // Control word for the state being entered; opcode/funct are stable from DECODE on.
  function automatic ctrl_t state_ctrl(input state_t s, input logic [5:0] op,
                                       input logic [2:0] r_alu);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read = 1'b1; c.ir_write = 1'b1; c.pc_write = 1'b1;
        c.alu_src_b = 2'b01; c.alu_cntrl = ALU_ADD;
      end
      S_DECODE:    begin c.alu_src_b = 2'b11; c.alu_cntrl = ALU_ADD; end
      S_MEM_ADDR:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_cntrl = ALU_ADD; end
      S_MEM_READ:  begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
      S_MEM_WB:    begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      S_MEM_WRITE: begin c.mem_write = 1'b1; c.i_or_d = 1'b1; end
      S_R_EXEC:    begin c.alu_src_a = 1'b1; c.alu_cntrl = r_alu; end
      S_R_WB:      begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
      S_BRANCH: begin
        c.alu_src_a = 1'b1; c.alu_cntrl = ALU_SUB;
        c.pc_src = 2'b01; c.pc_write_cond = 1'b1;
      end
      S_I_EXEC: begin
        c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
        c.alu_cntrl = (op == OP_SLTI) ? ALU_SLT : ALU_ADD;
      end
      S_I_WB:  c.reg_write = 1'b1;
      S_JUMP:  begin c.pc_write = 1'b1; c.pc_src = 2'b10; end
      S_JAL: begin
        c.pc_write = 1'b1; c.pc_src = 2'b10; c.reg_write = 1'b1;
        c.jal_reg = 1'b1; c.pc_to_reg = 1'b1;
      end
      S_JR:    begin c.pc_write = 1'b1; c.pc_src = 2'b11; end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/multi_cycle_controller_alu_control.sv
// ============================================================================
// alu_control : R-type funct -> ALU operation code with a legality flag
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_control
  import multi_cycle_controller_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [2:0] alu_cntrl_o,
  output logic       valid_o
);

  always_comb begin
    alu_cntrl_o = ALU_AND;
    valid_o     = 1'b1;
    case (funct_i)
      FN_ADD:  alu_cntrl_o = ALU_ADD;
      FN_SUB:  alu_cntrl_o = ALU_SUB;
      FN_AND:  alu_cntrl_o = ALU_AND;
      FN_OR:   alu_cntrl_o = ALU_OR;
      FN_SLT:  alu_cntrl_o = ALU_SLT;
      default: valid_o     = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multi_cycle_controller.sv
// ============================================================================
// multi_cycle_controller : multi-cycle MIPS control FSM with retire counter
// Rev 1.0
// ============================================================================
`default_nettype none

module multi_cycle_controller
  import multi_cycle_controller_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             jal_reg,
  output logic             mem_to_reg,
  output logic             pc_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_cntrl,
  output logic [1:0]       pc_src,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired
);

  state_t           state_q, state_d;
  ctrl_t            ctrl_q;
  logic [CNT_W-1:0] retired_q;
  logic [2:0]       r_alu;
  logic             r_valid;
  logic             illegal;
  logic             retire;

  alu_control u_alu_control (
    .funct_i     (funct),
    .alu_cntrl_o (r_alu),
    .valid_o     (r_valid)
  );

  always_comb begin
    state_d = S_INIT;
    illegal = 1'b0;
    retire  = 1'b0;
    case (state_q)
      S_INIT:   state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:     state_d = S_MEM_ADDR;
          OP_R:             state_d = (funct == FN_JR) ? S_JR : S_R_EXEC;
          OP_BEQ:           state_d = S_BRANCH;
          OP_ADDI, OP_SLTI: state_d = S_I_EXEC;
          OP_J:             state_d = S_JUMP;
          OP_JAL:           state_d = S_JAL;
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ: state_d = S_MEM_WB;
      S_R_EXEC: begin
        state_d = r_valid ? S_R_WB : S_FETCH;
        illegal = ~r_valid;
      end
      S_I_EXEC: state_d = S_I_WB;
      S_MEM_WB, S_MEM_WRITE, S_R_WB, S_BRANCH, S_I_WB, S_JUMP, S_JAL, S_JR: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default: state_d = S_INIT;
    endcase
  end

  // Outputs are registered alongside the state so they are glitch-free Moore outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_INIT;
      ctrl_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= state_ctrl(state_d, opcode, r_alu);
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign pc_write      = ctrl_q.pc_write | (ctrl_q.pc_write_cond & zero);
  assign pc_write_cond = ctrl_q.pc_write_cond;
  assign i_or_d        = ctrl_q.i_or_d;
  assign mem_read      = ctrl_q.mem_read;
  assign mem_write     = ctrl_q.mem_write;
  assign ir_write      = ctrl_q.ir_write;
  assign reg_dst       = ctrl_q.reg_dst;
  assign jal_reg       = ctrl_q.jal_reg;
  assign mem_to_reg    = ctrl_q.mem_to_reg;
  assign pc_to_reg     = ctrl_q.pc_to_reg;
  assign reg_write     = ctrl_q.reg_write;
  assign alu_src_a     = ctrl_q.alu_src_a;
  assign alu_src_b     = ctrl_q.alu_src_b;
  assign alu_cntrl     = ctrl_q.alu_cntrl;
  assign pc_src        = ctrl_q.pc_src;
  assign illegal_op    = illegal;
  assign retired       = retired_q;

endmodule

`default_nettype wire

// File: tb/tb_multi_cycle_controller.sv
// ============================================================================
// tb_multi_cycle_controller : random instruction stream vs. per-instruction model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_multi_cycle_controller;

  localparam int CNT_W = 4;
  localparam logic [20:0] FETCH_VEC = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
                                       1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 3'b010, 2'b00, 1'b0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic zero = 1'b0;
  logic pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_dst;
  logic jal_reg, mem_to_reg, pc_to_reg, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_cntrl;
  logic [CNT_W-1:0] retired;
  logic [CNT_W-1:0] retired_m = '0;
  wire  [20:0] outs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_dst,
                       jal_reg, mem_to_reg, pc_to_reg, reg_write, alu_src_a, alu_src_b,
                       alu_cntrl, pc_src, illegal_op};

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  multi_cycle_controller #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .jal_reg(jal_reg), .mem_to_reg(mem_to_reg),
    .pc_to_reg(pc_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_cntrl(alu_cntrl), .pc_src(pc_src),
    .illegal_op(illegal_op), .retired(retired)
  );

  // Instruction-level expectations: totals over one instruction, not per-state outputs.
  typedef struct {
    int         cpi;
    int         regw;
    int         memw;
    int         memr;
    int         pcw;
    int         ill;
    int         jal;
    bit         ret;
    bit         chk_alu;
    logic [2:0] alu;
    logic [1:0] pcs;
    logic       rdst;
    logic       m2r;
  } exp_t;

  function automatic exp_t model(input logic [5:0] op, input logic [5:0] fn, input logic z);
    exp_t e;
    e = '{cpi: 2, regw: 0, memw: 0, memr: 0, pcw: 0, ill: 1, jal: 0, ret: 1'b0,
          chk_alu: 1'b1, alu: 3'b011, pcs: 2'b00, rdst: 1'b0, m2r: 1'b0};
    case (op)
      6'b100011: begin e.cpi = 5; e.regw = 1; e.memr = 1; e.m2r = 1'b1; e.alu = 3'b010; end
      6'b101011: begin e.cpi = 4; e.memw = 1; e.alu = 3'b010; end
      6'b000100: begin e.cpi = 3; e.pcw = int'(z); e.pcs = 2'b01; e.alu = 3'b110; end
      6'b001000: begin e.cpi = 4; e.regw = 1; e.alu = 3'b010; end
      6'b001010: begin e.cpi = 4; e.regw = 1; e.alu = 3'b111; end
      6'b000010: begin e.cpi = 3; e.pcw = 1; e.pcs = 2'b10; end
      6'b000011: begin e.cpi = 3; e.pcw = 1; e.pcs = 2'b10; e.regw = 1; e.jal = 1; end
      6'b000000: begin
        e.cpi = 4; e.regw = 1; e.rdst = 1'b1;
        case (fn)
          6'b100000: e.alu = 3'b010;
          6'b100010: e.alu = 3'b110;
          6'b100100: e.alu = 3'b000;
          6'b100101: e.alu = 3'b001;
          6'b101010: e.alu = 3'b111;
          6'b001000: begin e.cpi = 3; e.regw = 0; e.rdst = 1'b0; e.pcw = 1; e.pcs = 2'b11; end
          default: begin e.cpi = 3; e.regw = 0; e.rdst = 1'b0; e.chk_alu = 1'b0; end
        endcase
      end
      default: ;
    endcase
    if (e.cpi != 2 && !(op == 6'b000000 && e.chk_alu == 1'b0)) begin
      e.ill = 0;
      e.ret = 1'b1;
    end
    return e;
  endfunction

  // Runs one instruction starting at a negedge inside FETCH; returns at the next FETCH.
  task automatic exec_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
    exp_t e;
    int steps, regw, memw, memr, pcw, ill, jal;
    logic [2:0] alu_seen;
    logic [1:0] pcs_seen;
    logic rdst_seen, m2r_seen;
    bit done;
    opcode = op; funct = fn; zero = z;
    e = model(op, fn, z);
    vectors++;
    if (outs !== FETCH_VEC) begin
      errors++;
      $display("FAIL fetch_outs op=%b fn=%b got=%b want=%b", op, fn, outs, FETCH_VEC);
    end
    steps = 1; regw = 0; memw = 0; memr = 0; pcw = 0; ill = 0; jal = 0;
    alu_seen = 3'b011; pcs_seen = 2'b00; rdst_seen = 1'b0; m2r_seen = 1'b0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (ir_write === 1'b1) begin
        done = 1'b1;
      end else begin
        steps++;
        regw += int'(reg_write);
        memw += int'(mem_write);
        memr += int'(mem_read);
        pcw  += int'(pc_write);
        ill  += int'(illegal_op);
        jal  += int'(jal_reg & pc_to_reg & reg_write);
        if (alu_src_a) alu_seen = alu_cntrl;
        if (pc_write || pc_write_cond) pcs_seen = pc_src;
        if (reg_write) begin rdst_seen = reg_dst; m2r_seen = mem_to_reg; end
        if (steps > 12) begin
          vectors++; errors++;
          $display("FAIL timeout op=%b fn=%b got=%0d cycles want=%0d", op, fn, steps, e.cpi);
          return;
        end
      end
    end
    if (e.ret) retired_m = retired_m + 1'b1;
    vectors += 11;
    if (steps != e.cpi) begin errors++; $display("FAIL cycles op=%b fn=%b got=%0d want=%0d", op, fn, steps, e.cpi); end
    if (regw != e.regw) begin errors++; $display("FAIL reg_write op=%b fn=%b got=%0d want=%0d", op, fn, regw, e.regw); end
    if (memw != e.memw) begin errors++; $display("FAIL mem_write op=%b got=%0d want=%0d", op, memw, e.memw); end
    if (memr != e.memr) begin errors++; $display("FAIL mem_read op=%b got=%0d want=%0d", op, memr, e.memr); end
    if (pcw != e.pcw) begin errors++; $display("FAIL pc_write op=%b fn=%b z=%b got=%0d want=%0d", op, fn, z, pcw, e.pcw); end
    if (ill != e.ill) begin errors++; $display("FAIL illegal op=%b fn=%b got=%0d want=%0d", op, fn, ill, e.ill); end
    if (jal != e.jal) begin errors++; $display("FAIL jal_link op=%b got=%0d want=%0d", op, jal, e.jal); end
    if (pcs_seen !== e.pcs) begin errors++; $display("FAIL pc_src op=%b fn=%b got=%b want=%b", op, fn, pcs_seen, e.pcs); end
    if (rdst_seen !== e.rdst) begin errors++; $display("FAIL reg_dst op=%b got=%b want=%b", op, rdst_seen, e.rdst); end
    if (m2r_seen !== e.m2r) begin errors++; $display("FAIL mem_to_reg op=%b got=%b want=%b", op, m2r_seen, e.m2r); end
    if (retired !== retired_m) begin errors++; $display("FAIL retired op=%b fn=%b got=%0d want=%0d", op, fn, retired, retired_m); end
    if (e.chk_alu) begin
      vectors++;
      if (alu_seen !== e.alu) begin errors++; $display("FAIL alu_cntrl op=%b fn=%b got=%b want=%b", op, fn, alu_seen, e.alu); end
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    vectors += 2;
    if (outs !== '0) begin errors++; $display("FAIL reset_outs got=%b want=0", outs); end
    if (retired !== '0) begin errors++; $display("FAIL reset_retired got=%0d want=0", retired); end
    rst = 1'b1;
    @(negedge clk);
    retired_m = '0;
    vectors++;
    if (outs !== FETCH_VEC) begin errors++; $display("FAIL first_fetch got=%b want=%b", outs, FETCH_VEC); end
  endtask

  task automatic test_directed();
    exec_instr(6'b100011, 6'd0, 1'b0);       // lw
    exec_instr(6'b000000, 6'b100010, 1'b0);  // sub
    exec_instr(6'b000100, 6'd0, 1'b1);       // beq taken
    exec_instr(6'b000100, 6'd0, 1'b0);       // beq not taken
    exec_instr(6'b000011, 6'd0, 1'b0);       // jal
    exec_instr(6'b000000, 6'b001000, 1'b0);  // jr
    exec_instr(6'b111111, 6'd0, 1'b0);       // illegal opcode
    exec_instr(6'b101011, 6'd0, 1'b0);       // sw
  endtask

  task automatic test_midreset();
    opcode = 6'b100011; funct = 6'd0;
    repeat (3) @(negedge clk);
    vectors++;
    if (!(mem_read === 1'b1 && i_or_d === 1'b1)) begin
      errors++; $display("FAIL midreset_memread got=%b%b want=11", mem_read, i_or_d);
    end
    #2 rst = 1'b0;
    #1;
    vectors += 2;
    if (outs !== '0) begin errors++; $display("FAIL midreset_outs got=%b want=0", outs); end
    if (retired !== '0) begin errors++; $display("FAIL midreset_retired got=%0d want=0", retired); end
    retired_m = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (outs !== FETCH_VEC) begin errors++; $display("FAIL post_reset_fetch got=%b want=%b", outs, FETCH_VEC); end
  endtask

  task automatic test_random(input int n);
    logic [5:0] ops [8];
    logic [5:0] fns [6];
    logic [5:0] op, fn;
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b001010, 6'b000010, 6'b000011};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b001000};
    for (int i = 0; i < n; i++) begin
      op = ops[$urandom_range(0, 7)];
      fn = fns[$urandom_range(0, 5)];
      if ($urandom_range(0, 9) == 0) begin
        op = 6'($urandom_range(0, 63));
        fn = 6'($urandom_range(0, 63));
      end
      exec_instr(op, fn, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_wrap();
    int guard = 0;
    while (retired_m != {CNT_W{1'b1}} && guard < 40) begin
      exec_instr(6'b000010, 6'd0, 1'b0);
      guard++;
    end
    exec_instr(6'b000010, 6'd0, 1'b0);
    vectors++;
    if (retired !== '0) begin errors++; $display("FAIL wrap got=%0d want=0", retired); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_midreset();
    test_random(80);
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
